// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter with registered one-hot grant and valid/ready output
// Optional burst ownership via ARB_LOCK_EN (adds the lock port).
module rr_grant_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
`ifdef ARB_LOCK_EN
  input  logic                      lock,
`endif
  input  logic                      grant_ready,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic                      grant_valid
);

  localparam int N = NUM_REQUESTERS;

  logic [N-1:0] grant_oh_q, grant_oh_d;
  logic         grant_valid_q, grant_valid_d;
  logic [N-1:0] priority_oh_q, priority_oh_d;

  logic         accept;
  logic         load;
  logic         lock_hold;
  logic [N-1:0] winner_next;
  logic [N-1:0] base_oh;
  logic [N-1:0] pick_oh;
  logic         scan_armed;
  logic         scan_found;

  assign accept = grant_valid_q & grant_ready;
  assign load   = ~grant_valid_q | accept;

`ifdef ARB_LOCK_EN
  assign lock_hold = accept & lock & (|(request & grant_oh_q));
`else
  assign lock_hold = 1'b0;
`endif

  // Rotate left by one; for N=1 this degenerates to the identity.
  always_comb begin
    winner_next = '0;
    for (int i = 0; i < N; i++) begin
      winner_next[(i + 1) % N] = grant_oh_q[i];
    end
  end

  assign base_oh = accept ? winner_next : priority_oh_q;

  // Walk two laps of the ring: the first lap arms at the base bit, so the
  // first armed request seen is the nearest one at or above base, wrapping.
  always_comb begin
    pick_oh    = '0;
    scan_armed = 1'b0;
    scan_found = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (j < N && base_oh[j % N]) begin
        scan_armed = 1'b1;
      end
      if (scan_armed && !scan_found && request[j % N]) begin
        pick_oh[j % N] = 1'b1;
        scan_found     = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh_d    = grant_oh_q;
    grant_valid_d = grant_valid_q;
    priority_oh_d = priority_oh_q;
    if (load) begin
      grant_oh_d    = lock_hold ? grant_oh_q : pick_oh;
      grant_valid_d = |request;
      if (accept && !lock_hold) begin
        priority_oh_d = base_oh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_oh_q    <= '0;
      grant_valid_q <= 1'b0;
      priority_oh_q <= N'(1);
    end else begin
      grant_oh_q    <= grant_oh_d;
      grant_valid_q <= grant_valid_d;
      priority_oh_q <= priority_oh_d;
    end
  end

  assign grant_oh    = grant_oh_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed self-checking bench for rr_grant_arbiter
// Lock scenarios run only when ARB_LOCK_EN is defined.
module tb_rr_grant_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] request;
  logic       lock;
  logic       grant_ready;
  logic [3:0] grant_oh;
  logic       grant_valid;

  int tests_run;
  int tests_failed;

  rr_grant_arbiter #(.NUM_REQUESTERS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant_ready (grant_ready),
    .grant_oh    (grant_oh),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    request     = 4'b0000;
    grant_ready = 1'b0;
    lock        = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    request     = 4'b1111;
    grant_ready = 1'b1;
    lock        = 1'b0;
    step();
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b0_0000) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b grant=%b, want valid=0 grant=0000", grant_valid, grant_oh);
    end
    reset = 1'b0;
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;
    do_reset();
    request     = 4'b1111;
    grant_ready = 1'b1;
    tests_run++;
    if (grant_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rotation_idle: got valid=%b, want 0", grant_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if ({grant_valid, grant_oh} !== {1'b1, exp_seq[i]}) begin
        tests_failed++;
        $display("FAIL rotation_%0d: got valid=%b grant=%b, want valid=1 grant=%b", i, grant_valid, grant_oh, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    request     = 4'b1010;
    grant_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({grant_valid, grant_oh} !== 5'b1_0010) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got valid=%b grant=%b, want valid=1 grant=0010", i, grant_valid, grant_oh);
      end
    end
    grant_ready = 1'b1;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_1000) begin
      tests_failed++;
      $display("FAIL stall_release_a: got valid=%b grant=%b, want valid=1 grant=1000", grant_valid, grant_oh);
    end
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_0010) begin
      tests_failed++;
      $display("FAIL stall_release_b: got valid=%b grant=%b, want valid=1 grant=0010", grant_valid, grant_oh);
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    request     = 4'b1000;
    grant_ready = 1'b1;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_1000) begin
      tests_failed++;
      $display("FAIL wrap_top: got valid=%b grant=%b, want valid=1 grant=1000", grant_valid, grant_oh);
    end
    request = 4'b0011;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_0001) begin
      tests_failed++;
      $display("FAIL wrap_a: got valid=%b grant=%b, want valid=1 grant=0001", grant_valid, grant_oh);
    end
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_0010) begin
      tests_failed++;
      $display("FAIL wrap_b: got valid=%b grant=%b, want valid=1 grant=0010", grant_valid, grant_oh);
    end
  endtask

  task automatic test_empty();
    do_reset();
    request     = 4'b0000;
    grant_ready = 1'b1;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b0_0000) begin
      tests_failed++;
      $display("FAIL empty_idle: got valid=%b grant=%b, want valid=0 grant=0000", grant_valid, grant_oh);
    end
    request     = 4'b0100;
    grant_ready = 1'b0;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_0100) begin
      tests_failed++;
      $display("FAIL empty_single: got valid=%b grant=%b, want valid=1 grant=0100", grant_valid, grant_oh);
    end
    request = 4'b0000;
    step();
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_0100) begin
      tests_failed++;
      $display("FAIL empty_committed: got valid=%b grant=%b, want valid=1 grant=0100", grant_valid, grant_oh);
    end
    grant_ready = 1'b1;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b0_0000) begin
      tests_failed++;
      $display("FAIL empty_drain: got valid=%b grant=%b, want valid=0 grant=0000", grant_valid, grant_oh);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    request     = 4'b0100;
    grant_ready = 1'b0;
    step();
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_0100) begin
      tests_failed++;
      $display("FAIL midstall_setup: got valid=%b grant=%b, want valid=1 grant=0100", grant_valid, grant_oh);
    end
    reset = 1'b1;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b0_0000) begin
      tests_failed++;
      $display("FAIL midstall_reset: got valid=%b grant=%b, want valid=0 grant=0000", grant_valid, grant_oh);
    end
    reset       = 1'b0;
    request     = 4'b1111;
    grant_ready = 1'b1;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_0001) begin
      tests_failed++;
      $display("FAIL midstall_first: got valid=%b grant=%b, want valid=1 grant=0001", grant_valid, grant_oh);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b0010;
    exp_seq[1] = 4'b1000;
    exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b1000;
    do_reset();
    request     = 4'b1010;
    grant_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if ({grant_valid, grant_oh} !== {1'b1, exp_seq[i]}) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got valid=%b grant=%b, want valid=1 grant=%b", i, grant_valid, grant_oh, exp_seq[i]);
      end
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    request     = 4'b1111;
    grant_ready = 1'b1;
    step();
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_0010) begin
      tests_failed++;
      $display("FAIL lock_setup: got valid=%b grant=%b, want valid=1 grant=0010", grant_valid, grant_oh);
    end
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({grant_valid, grant_oh} !== 5'b1_0010) begin
        tests_failed++;
        $display("FAIL lock_hold_%0d: got valid=%b grant=%b, want valid=1 grant=0010", i, grant_valid, grant_oh);
      end
    end
    lock = 1'b0;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_0100) begin
      tests_failed++;
      $display("FAIL lock_release: got valid=%b grant=%b, want valid=1 grant=0100", grant_valid, grant_oh);
    end
    lock    = 1'b1;
    request = 4'b1011;
    step();
    tests_run++;
    if ({grant_valid, grant_oh} !== 5'b1_1000) begin
      tests_failed++;
      $display("FAIL lock_dropped: got valid=%b grant=%b, want valid=1 grant=1000", grant_valid, grant_oh);
    end
    lock = 1'b0;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    request      = 4'b0000;
    grant_ready  = 1'b0;
    lock         = 1'b0;
    test_reset();
    test_rotation();
    test_stall_hold();
    test_wrap_skip();
    test_empty();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that picks one of NUM_REQUESTERS request lines and presents a registered one-hot grant with a valid/ready handshake.
- Sits directly upstream of the one-hot-to-index converter; the consumer turns grant_oh into a binary index for mux select and thread ID.
- Rotating priority gives starvation-free fairness among strands and threads competing for a shared pipeline slot.

Parameters:
- NUM_REQUESTERS, 4, number of request lines. Legal range is 1 or more. Any value is allowed, not only powers of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- request  input  NUM_REQUESTERS  per-requester request; bit i means requester i wants the slot.
- grant_oh  output  NUM_REQUESTERS  registered one-hot grant; all zero when grant_valid=0.
- grant_valid  output  1  grant_oh holds a committed grant.
- grant_ready  input  1  consumer accepts the grant this cycle.
- lock  input  1  present only with ARB_LOCK_EN; holds the current winner for the next grant.

Behaviour:
- Reset values:
  - grant_oh=0, grant_valid=0.
  - Priority register priority_oh = one-hot bit 0, so requester 0 has highest priority.
  - Reset wins over all other inputs, including in the middle of a stalled grant.
- Accept condition: accept = grant_valid & grant_ready.
- Load condition: load = ~grant_valid | accept.
- Scan base:
  - If accept, base = grant_oh rotated left by 1, i.e. the position just after the current winner.
  - Otherwise base = priority_oh.
- Pick (combinational): the first set bit of request found scanning upward from base, inclusive, wrapping from bit N-1 to bit 0. Result is one-hot, or zero if request=0.
- Registered update on each rising edge when load=1:
  - grant_oh <= pick.
  - grant_valid <= |request.
  - If accept, priority_oh <= base.
- When load=0 (stalled): grant_oh, grant_valid and priority_oh all hold.
- Latency: a request arriving while idle produces grant_valid on the next edge, so one cycle of latency.
- Back-to-back throughput: with grant_ready held high, a new grant issues every cycle.
- Committed grants:
  - A grant, once valid, stays fixed until accepted, even if its request bit drops.
  - Requesters must hold request until accepted. A violation still completes the transfer and causes no corruption.
- Request changes during a stall have no effect until the next load.
- If request=0 on a load: grant_valid=0, grant_oh=0. priority_oh updates only if that load was an accept.
- Invariant: grant_oh is zero or exactly one-hot at all times, and is nonzero exactly when grant_valid=1.
- NUM_REQUESTERS=1: the rotation is the identity; the block degenerates to a registered valid/ready stage.
- No combinational path from grant_ready to grant_oh or grant_valid. There is a combinational path from request to the internal pick only.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With the macro defined:
  - The lock port exists.
  - On accept with lock=1, if request still contains the current winner, pick = grant_oh and priority_oh is not advanced. This allows burst ownership.
  - If the winner has dropped its request, normal round-robin applies from the rotated base.
  - lock is ignored when accept=0.
- Without the macro: no lock port; behaviour is identical to lock=0.

Test Plan:
- Rotation: reset, then request=4'b1111, grant_ready=1 constantly. Required: grant_valid rises 1 cycle after reset deasserts; grant_oh sequence is 0001, 0010, 0100, 1000, 0001, one per cycle.
- Stall hold: request=4'b1010, grant_ready=0 for 3 cycles. Required: grant_oh=0010 with grant_valid=1 stable for all 3 cycles. Then grant_ready=1. Required: next grant_oh=1000, then 0010.
- Wrap and skip: accept grant 1000, then request=4'b0011. Required: next grant_oh=0001, then 0010. Bit order wraps correctly across the top.
- Empty: request=0. Required: grant_valid=0, grant_oh=0. Then request=4'b0100 for one cycle. Required: grant_valid=1 with grant_oh=0100 on the next edge; the grant holds until ready even though request has dropped.
- Reset mid-stall: grant_oh=0100 valid with grant_ready=0, then assert reset for 1 cycle. Required: grant_valid=0, grant_oh=0 next cycle. With request=1111 afterwards, the first grant is 0001.
- Lock (ARB_LOCK_EN): request=1111, lock=1, winner 0010, three accepts. Required: grant_oh=0010 each time. Then lock=0 on the next accept. Required: next grant_oh=0100.
